// File: rtl/vga_arb_pkg.sv
// ----------------------------------------------------------------------------
// vga_arb_pkg
//   Shared widths and types for the VGA plot arbiter.
//   VGA_X_W / VGA_Y_W / VGA_C_W : coordinate and colour widths of the
//                                 160x120, 3-bit colour adapter.
//   arb_state_t                 : arbiter FSM state (IDLE, OWN).
//   Optional build macro used by the arbiter: VGA_ARB_BURST_LIMIT_EN.
// ----------------------------------------------------------------------------
package vga_arb_pkg;

    localparam int VGA_X_W = 8;
    localparam int VGA_Y_W = 7;
    localparam int VGA_C_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage : vga_arb_pkg

// File: rtl/vga_plot_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority encoder. Returns the first set request
//   at or after index ptr, wrapping past N_REQ-1 back to 0.
//   Ports:
//     req  [N_REQ-1:0] in  : request vector
//     ptr  [PTR_W-1:0] in  : highest-priority index
//     sel  [PTR_W-1:0] out : chosen index (0 when any is low)
//     any              out : at least one request set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] sel,
    output logic             any
);

    always_comb begin
        int idx;
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = PTR_W'(idx);
            end
        end
    end

endmodule : rr_pick

// File: rtl/vga_plot_arbiter.sv
// ----------------------------------------------------------------------------
// vga_plot_arbiter
//   Shares the single pixel-write port of the 160x120 VGA adapter between
//   N_REQ drawing engines. Round-robin ownership, registered pixel output.
//
//   Ownership handshake (req/grant): an engine raises req and holds it for
//   the whole burst. grant[i] rises one cycle after the arbiter picks it and
//   stays high until the cycle after req[i] falls (or a forced rotation).
//   While grant[i] is high, every cycle with plot_in[i]=1 transfers one
//   pixel; the arbiter never stalls an owner, so plot_in acts as valid with
//   an implicit always-ready. plot_in from non-owners is dropped.
//
//   Ports:
//     clk, rst (async, active-high)
//     req[N_REQ], plot_in[N_REQ]           : per-engine request / pixel strobe
//     x_in, y_in, colour_in                : packed per-engine pixel data
//     grant[N_REQ], owner, busy            : registered ownership status
//     vga_x, vga_y, vga_colour, vga_plot   : registered pixel to the adapter
//     state_dbg                            : current FSM state
//
//   Build option: VGA_ARB_BURST_LIMIT_EN enables forced rotation after
//   BURST_MAX accepted pixels when another engine is waiting.
// ----------------------------------------------------------------------------
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int BURST_MAX = 19200,
    localparam int PTR_W    = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           plot_in,
    input  logic [N_REQ*VGA_X_W-1:0]   x_in,
    input  logic [N_REQ*VGA_Y_W-1:0]   y_in,
    input  logic [N_REQ*VGA_C_W-1:0]   colour_in,
    output logic [N_REQ-1:0]           grant,
    output logic [PTR_W-1:0]           owner,
    output logic                       busy,
    output logic [VGA_X_W-1:0]         vga_x,
    output logic [VGA_Y_W-1:0]         vga_y,
    output logic [VGA_C_W-1:0]         vga_colour,
    output logic                       vga_plot,
    output arb_state_t                 state_dbg
);

    if (N_REQ < 2 || N_REQ > 8 || BURST_MAX < 1) begin : g_bad_params
        $error("vga_plot_arbiter: N_REQ must be 2..8 and BURST_MAX >= 1");
    end

    arb_state_t        state, next_state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  pick_sel;
    logic              pick_any;

    // Decoded per-cycle actions (output comb)
    logic              take_grant;
    logic              accept;
    logic              release_now;
    logic              force_rel;
    logic [PTR_W-1:0]  ptr_after;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .any (pick_any)
    );

`ifdef VGA_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    logic [CNT_W-1:0]  burst_cnt;
    logic [N_REQ-1:0]  other_req;

    assign other_req = req & ~(N_REQ'(1) << owner);

    // The pixel being accepted now is the BURST_MAXth (or a later one after
    // saturation); only rotate if someone else is actually waiting.
    assign force_rel = accept && (burst_cnt >= CNT_W'(BURST_MAX - 1)) && (|other_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            burst_cnt <= '0;
        end else if (accept && (burst_cnt < CNT_W'(BURST_MAX))) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_any)    next_state = OWN;
            OWN:     if (release_now) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    // In OWN, grant[owner] is the only grant bit set, so acceptance reduces
    // to the owner's own strobe.
    always_comb begin
        take_grant  = (state == IDLE) && pick_any;
        accept      = (state == OWN) && plot_in[owner];
        release_now = (state == OWN) && (!req[owner] || force_rel);
        ptr_after   = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    end

    assign state_dbg = state;

    // ---------------- ownership registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
            owner <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
        end else if (take_grant) begin
            grant <= N_REQ'(1) << pick_sel;
            owner <= pick_sel;
            busy  <= 1'b1;
        end else if (release_now) begin
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_after;
        end
    end

    // ---------------- pixel pipeline ----------------
    // Coordinates hold their last value when nothing is plotted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= accept;
            if (accept) begin
                vga_x      <= x_in[int'(owner)*VGA_X_W +: VGA_X_W];
                vga_y      <= y_in[int'(owner)*VGA_Y_W +: VGA_Y_W];
                vga_colour <= colour_in[int'(owner)*VGA_C_W +: VGA_C_W];
            end
        end
    end

endmodule : vga_plot_arbiter

// File: tb/tb_vga_plot_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vga_plot_arbiter
//   Directed bench for vga_plot_arbiter with N_REQ=2, BURST_MAX=4.
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   that same point, so each check sees the result of the preceding edge.
// ----------------------------------------------------------------------------
module tb_vga_plot_arbiter;
    import vga_arb_pkg::*;

    localparam int N_REQ = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         plot_in;
    logic [N_REQ*VGA_X_W-1:0] x_in;
    logic [N_REQ*VGA_Y_W-1:0] y_in;
    logic [N_REQ*VGA_C_W-1:0] colour_in;
    logic [N_REQ-1:0]         grant;
    logic                     owner;
    logic                     busy;
    logic [VGA_X_W-1:0]       vga_x;
    logic [VGA_Y_W-1:0]       vga_y;
    logic [VGA_C_W-1:0]       vga_colour;
    logic                     vga_plot;
    arb_state_t               state_dbg;

    vga_plot_arbiter #(
        .N_REQ     (N_REQ),
        .BURST_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .plot_in    (plot_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .grant      (grant),
        .owner      (owner),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .state_dbg  (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input int eng, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] c);
        x_in[eng*VGA_X_W +: VGA_X_W]      = x;
        y_in[eng*VGA_Y_W +: VGA_Y_W]      = y;
        colour_in[eng*VGA_C_W +: VGA_C_W] = c;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input logic p, input logic [7:0] x,
                          input logic [6:0] y, input logic [2:0] c);
        chk({tag, "_plot"}, 32'(vga_plot), 32'(p));
        chk({tag, "_x"}, 32'(vga_x), 32'(x));
        chk({tag, "_y"}, 32'(vga_y), 32'(y));
        chk({tag, "_c"}, 32'(vga_colour), 32'(c));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req = '0; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;

        // reset state
        step(); step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk_px("rst_px", 1'b0, 8'd0, 7'd0, 3'd0);
        rst = 1'b0;

        // single engine: grant latency and two back-to-back pixels
        req = 2'b01;
        step();
        chk("g0_grant", 32'(grant), 32'h1);
        chk("g0_busy", 32'(busy), 32'h1);
        chk("g0_state", 32'(state_dbg), 32'(OWN));
        plot_in = 2'b01; drive_px(0, 8'd5, 7'd7, 3'b100);
        step();
        chk_px("px1", 1'b1, 8'd5, 7'd7, 3'b100);
        drive_px(0, 8'd159, 7'd119, 3'b001);
        step();
        chk_px("px2", 1'b1, 8'd159, 7'd119, 3'b001);
        plot_in = 2'b00;
        step();
        chk_px("hold", 1'b0, 8'd159, 7'd119, 3'b001);

        // isolation: non-owner strobe must not reach the adapter
        plot_in = 2'b10; drive_px(1, 8'd1, 7'd1, 3'b111);
        step();
        chk_px("iso", 1'b0, 8'd159, 7'd119, 3'b001);
        chk("iso_grant", 32'(grant), 32'h1);

        // release-cycle pixel is still accepted; ptr moves to 1
        req = 2'b00; plot_in = 2'b01; drive_px(0, 8'd10, 7'd20, 3'b010);
        step();
        chk("rel_grant", 32'(grant), 32'h0);
        chk("rel_busy", 32'(busy), 32'h0);
        chk_px("rel_px", 1'b1, 8'd10, 7'd20, 3'b010);
        plot_in = 2'b00;
        step();
        chk("idle_plot", 32'(vga_plot), 32'h0);
        chk("idle_state", 32'(state_dbg), 32'(IDLE));

        // contention with ptr=1: engine 1 wins
        req = 2'b11;
        step();
        chk("rot_grant", 32'(grant), 32'h2);
        chk("rot_owner", 32'(owner), 32'h1);
        // engine 1 releases; engine 0 waits one idle cycle then wins
        req = 2'b01;
        step();
        chk("rot_rel", 32'(grant), 32'h0);
        step();
        chk("rot_g0", 32'(grant), 32'h1);
        chk("rot_o0", 32'(owner), 32'h0);
        // engine 0 releases with engine 1 waiting: gap cycle, then engine 1
        req = 2'b10;
        step();
        chk("gap_grant", 32'(grant), 32'h0);
        chk("gap_busy", 32'(busy), 32'h0);
        step();
        chk("next_grant", 32'(grant), 32'h2);
        req = 2'b00;
        step();
        chk("clr_grant", 32'(grant), 32'h0);

        // ptr is 0 now; both request, engine 0 streams while engine 1 waits
        req = 2'b11; plot_in = 2'b01; drive_px(0, 8'd0, 7'd3, 3'b011);
        step();
        chk("bst_grant", 32'(grant), 32'h1);
        chk("bst_noplot", 32'(vga_plot), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            drive_px(0, 8'(k), 7'd3, 3'b011);
            step();
            chk_px("bst_px", 1'b1, 8'(k), 7'd3, 3'b011);
        end
`ifdef VGA_ARB_BURST_LIMIT_EN
        chk("bst_forced", 32'(grant), 32'h0);
        step();
        chk("bst_g1", 32'(grant), 32'h2);
        chk("bst_o1", 32'(owner), 32'h1);
        chk("bst_drop", 32'(vga_plot), 32'h0);
`else
        chk("bst_hold", 32'(grant), 32'h1);
        step();
        chk("bst_hold2", 32'(grant), 32'h1);
        chk("bst_more", 32'(vga_plot), 32'h1);
`endif
        req = 2'b00; plot_in = 2'b00;
        step(); step();
        chk("bst_end", 32'(busy), 32'h0);

        // asynchronous reset mid-burst (ptr back to 0 afterwards)
        req = 2'b01;
        step();
        chk("mr_grant", 32'(grant), 32'h1);
        plot_in = 2'b01; drive_px(0, 8'd77, 7'd55, 3'b110);
        step();
        chk("mr_plot", 32'(vga_plot), 32'h1);
        rst = 1'b1;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk_px("ar_px", 1'b0, 8'd0, 7'd0, 3'd0);
        step();
        rst = 1'b0;
        req = 2'b10; plot_in = 2'b00;
        step();
        chk("ar_g1", 32'(grant), 32'h2);
        chk("ar_o1", 32'(owner), 32'h1);
        req = 2'b00;
        step();

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vga_plot_arbiter

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single pixel-write port of the 160x120 VGA adapter between several drawing engines (fillscreen, line/circle drawers). Each engine requests ownership, receives an exclusive grant, streams pixels while granted, then releases. Round-robin between requesters; the winning pixel stream is registered and driven onto the adapter's `x`/`y`/`colour`/`plot` inputs.

## Interface
- `N_REQ`, default 2: number of requesting engines (2..8).
- `BURST_MAX`, default 19200: maximum pixels per grant before forced rotation (used only with `VGA_ARB_BURST_LIMIT_EN`).
- `clk` in 1: system clock (CLOCK_50 domain).
- `rst` in 1: reset, asynchronous, active-high.
- `req` in N_REQ: per-engine ownership request; level, held for the whole burst.
- `plot_in` in N_REQ: per-engine pixel-valid strobe.
- `x_in` in N_REQ*8: packed x coordinates, engine i at bits [8i+7:8i].
- `y_in` in N_REQ*7: packed y coordinates, engine i at bits [7i+6:7i].
- `colour_in` in N_REQ*3: packed colours, engine i at bits [3i+2:3i].
- `grant` out N_REQ: one-hot (or zero) ownership, registered.
- `owner` out $clog2(N_REQ): index of current/last owner.
- `busy` out 1: high while any grant is asserted.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3, `vga_plot` out 1: registered pixel to adapter.

## Operation
- States: IDLE, OWN. Rotating pointer `ptr` marks highest-priority index.
- IDLE: if any `req`, select first set bit at or after `ptr` (wrapping); next edge: `grant[sel]`=1, `owner`=sel, `busy`=1, state OWN. No req: stay IDLE.
- OWN: pixel accepted in a cycle iff `grant[i]` and `plot_in[i]`; accepted x/y/colour latched to `vga_*`, `vga_plot`=1 next cycle. Otherwise `vga_plot`=0 next cycle; `vga_x/y/colour` hold last values.
- Release: `req[owner]`=0 in OWN -> next edge `grant`=0, `busy`=0, `ptr`=owner+1 mod N_REQ, state IDLE. A pixel with `plot_in` in that same cycle is still accepted.
- Minimum one IDLE cycle between grants (grant never moves directly between engines).
- `plot_in` from non-owners ignored; never reaches adapter.
- Requests arriving while busy wait; no loss, no queue beyond the `req` level.
- Rst asserted at any time: all outputs to reset values immediately, in-flight pixel dropped, state IDLE, `ptr`=0.
- Reset values: `grant`=0, `owner`=0, `busy`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0.

## Timing
- Grant latency: `req` rising in IDLE -> `grant` high 1 cycle later.
- Pixel latency: accepted `plot_in` at edge k -> `vga_plot` high in cycle k+1; 1 pixel/cycle sustained.
- Release latency: `req` falling -> `grant` low 1 cycle later; next owner's `grant` no earlier than 2 cycles after release.
- Simultaneous `req` in IDLE: lowest index at or after `ptr` wins.

## Configuration
- `VGA_ARB_BURST_LIMIT_EN` defined: per-grant counter of accepted pixels (width $clog2(BURST_MAX+1)), cleared on each grant. When the BURST_MAXth pixel is accepted and any other `req` is set, forced release on the next edge exactly as a voluntary release (`ptr`=owner+1); the pre-empted engine keeps `req` high and re-wins later by rotation. With no competitor the counter saturates and the grant is held.
- Not defined: no counter, grant held until voluntary release; `BURST_MAX` unused.

## Structure
- Package `vga_arb_pkg`: `VGA_X_W`=8, `VGA_Y_W`=7, `VGA_C_W`=3, state enum `arb_state_t` {IDLE, OWN}.
- Sub-module `rr_pick`: combinational round-robin priority encoder (`req`, `ptr` -> `sel`, `any`); instantiated once.

## Test plan
- Reset: assert `rst` mid-burst -> `grant`=0, `vga_plot`=0, `busy`=0 same cycle; after release, `req`=2'b10 -> `grant`=2'b10 one cycle later.
- Single engine: engine 0 plots (5,7,3'b100) then (159,119,3'b001) on consecutive cycles -> `vga_*` show them on the following cycles with `vga_plot`=1.
- Contention: `req`=2'b11 from IDLE with `ptr`=0 -> engine 0 granted; engine 0 releases -> one IDLE cycle, then `grant`=2'b10.
- Isolation: engine 1 drives `plot_in` with (1,1,3'b111) while engine 0 owns and idles -> `vga_plot` stays 0.
- Release-cycle pixel: engine 0 drops `req` with `plot_in`=1 (10,20,3'b010) -> pixel appears on adapter, `grant` low the same cycle.
- Burst limit (macro on, BURST_MAX=4): engine 0 streams continuously, engine 1 requesting -> after 4 accepted pixels `grant` moves 2'b01 -> 0 -> 2'b10; macro off -> engine 0 keeps grant.
